lsu: RTL

LSU -- requirements
Module: lsu

---
 rtl/lsu.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit for an RV32I core: one request at a time, byte/half/word access
// to a word-wide data memory, with read-modify-write for sub-word stores.
module lsu #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t      state, state_n;
  logic [31:0] addr_q, wdata_q, merge_q;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic        fault;

  // Handshake: a request transfers on a rising edge with req_valid && req_ready;
  // resp_valid is a single-cycle pulse that the core must take (no backpressure).

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  load_ext = {{24{b[7]}}, b};
      3'b100:  load_ext = {24'd0, b};
      3'b001:  load_ext = {{16{h[15]}}, h};
      3'b101:  load_ext = {16'd0, h};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [31:0] merge_word(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] old, input logic [31:0] wd);
    merge_word = old;
    if (f3[1:0] == 2'b00) merge_word[{a, 3'b000} +: 8] = wd[7:0];
    else                  merge_word[{a[1], 4'b0000} +: 16] = wd[15:0];
  endfunction

  always_comb begin
    fault = 1'b0;
    if ((req_addr >> ADDR_BITS) != 32'd0) fault = 1'b1;
    if (req_funct3[1:0] == 2'b01 && req_addr[0]) fault = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) fault = 1'b1;
    if (req_we) begin
      if (req_funct3 > 3'b010) fault = 1'b1;
    end else if (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11) begin
      fault = 1'b1;
    end
  end

  always_comb begin
    state_n    = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_addr   = 32'd0;
    mem_we     = 1'b0;
    mem_wd     = 32'd0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = fault ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_addr = {addr_q[31:2], 2'b00};
        if (we_q && funct3_q[1:0] == 2'b10) begin
          mem_we  = 1'b1;
          mem_wd  = wdata_q;
          state_n = RESP;
        end else if (we_q) begin
          state_n = WRITE;
        end else begin
          state_n = RESP;
        end
      end
      WRITE: begin
        mem_addr = {addr_q[31:2], 2'b00};
        mem_we   = 1'b1;
        mem_wd   = merge_q;
        state_n  = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      merge_q    <= 32'd0;
      funct3_q   <= 3'd0;
      we_q       <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (req_valid) begin
          addr_q     <= req_addr;
          wdata_q    <= req_wdata;
          funct3_q   <= req_funct3;
          we_q       <= req_we;
          resp_rdata <= 32'd0;
          resp_err   <= fault;
        end
        ACCESS: begin
          // Sub-word stores read the old word here and write the merged word next cycle.
          if (!we_q) resp_rdata <= load_ext(funct3_q, addr_q[1:0], mem_rd);
          else if (funct3_q[1:0] != 2'b10)
            merge_q <= merge_word(funct3_q, addr_q[1:0], mem_rd, wdata_q);
        end
        default: ;
      endcase
    end
  end

  assign state_dbg = state;

endmodule
